// File: rtl/rxtx_echo_fifo_if.sv
// Byte stream bundle between rxuart, the echo FIFO and txuart, plus the
// FIFO's status and overflow-clear signals.
interface rxtx_echo_fifo_if #(
  parameter int unsigned LGFLEN = 4
) ();
  logic              rx_stb;
  logic [7:0]        rx_data;
  logic              tx_wr;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic [LGFLEN:0]   fill;
  logic              overflow;
  logic              clr_overflow;

  modport master (
    output rx_stb, rx_data, tx_busy, clr_overflow,
    input  tx_wr, tx_data, fill, overflow
  );

  modport slave (
    input  rx_stb, rx_data, tx_busy, clr_overflow,
    output tx_wr, tx_data, fill, overflow
  );
endinterface

// File: rtl/rxtx_echo_fifo.sv
// Elastic byte FIFO between rxuart and txuart with optional CR -> CR,LF
// expansion on the output side and a sticky overflow flag.
module rxtx_echo_fifo #(
  parameter int unsigned LGFLEN   = 4,
  parameter bit          OPT_CRLF = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  rxtx_echo_fifo_if.slave  bus
);

  localparam int unsigned     Depth   = 2 ** LGFLEN;
  localparam logic [LGFLEN:0] FullLvl = (LGFLEN + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StSend, StLf} state_e;

  logic [7:0]        mem [Depth];
  logic [LGFLEN-1:0] wr_ptr_q, wr_ptr_d;
  logic [LGFLEN-1:0] rd_ptr_q, rd_ptr_d;
  logic [LGFLEN:0]   fill_q, fill_d;
  logic              overflow_q, overflow_d;
  logic              tx_wr_q, tx_wr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  state_e            state_q, state_d;

  logic full, wr_en, pop, accept;

  // Full is judged on the registered fill, so a same-cycle pop never frees a slot.
  assign full   = (fill_q == FullLvl);
  assign wr_en  = bus.rx_stb && !full;
  assign accept = tx_wr_q && !bus.tx_busy;

  always_comb begin
    state_d   = state_q;
    tx_wr_d   = tx_wr_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fill_q != '0) begin
          pop       = 1'b1;
          tx_data_d = mem[rd_ptr_q];
          tx_wr_d   = 1'b1;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (accept) begin
          if (OPT_CRLF && (tx_data_q == 8'h0d)) begin
            tx_data_d = 8'h0a;
            state_d   = StLf;
          end else begin
            tx_wr_d = 1'b0;
            state_d = StIdle;
          end
        end
      end
      StLf: begin
        if (accept) begin
          tx_wr_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + LGFLEN'(wr_en);
    rd_ptr_d = rd_ptr_q + LGFLEN'(pop);
    fill_d   = fill_q;
    if (wr_en && !pop) begin
      fill_d = fill_q + 1'b1;
    end else if (!wr_en && pop) begin
      fill_d = fill_q - 1'b1;
    end
    // A drop in the same cycle as a clear leaves the flag set.
    overflow_d = overflow_q;
    if (bus.rx_stb && full) begin
      overflow_d = 1'b1;
    end else if (bus.clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= bus.rx_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
      tx_wr_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      state_q    <= StIdle;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
      tx_wr_q    <= tx_wr_d;
      tx_data_q  <= tx_data_d;
      state_q    <= state_d;
    end
  end

  assign bus.tx_wr    = tx_wr_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.fill     = fill_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_rxtx_echo_fifo.sv
// Bench for rxtx_echo_fifo: one CRLF-expanding and one pass-through instance
// share stimulus; output streams are compared against a queue-based model.
module tb_rxtx_echo_fifo;

  localparam int unsigned LGFLEN = 4;
  localparam int          Depth  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rxtx_echo_fifo_if #(.LGFLEN(LGFLEN)) ifc ();
  rxtx_echo_fifo_if #(.LGFLEN(LGFLEN)) ifn ();

  assign ifn.rx_stb       = ifc.rx_stb;
  assign ifn.rx_data      = ifc.rx_data;
  assign ifn.tx_busy      = ifc.tx_busy;
  assign ifn.clr_overflow = ifc.clr_overflow;

  rxtx_echo_fifo #(.LGFLEN(LGFLEN), .OPT_CRLF(1'b1)) dut_c (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (ifc.slave)
  );

  rxtx_echo_fifo #(.LGFLEN(LGFLEN), .OPT_CRLF(1'b0)) dut_n (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (ifn.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_c[$], exp_n[$], got_c[$], got_n[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: every accepted source byte yields itself, plus LF after CR when expanding.
  task automatic strobe(input logic [7:0] b, input bit keep);
    ifc.rx_stb  = 1'b1;
    ifc.rx_data = b;
    if (keep) begin
      exp_c.push_back(b);
      if (b == 8'h0d) exp_c.push_back(8'h0a);
      exp_n.push_back(b);
    end
    tick();
    ifc.rx_stb = 1'b0;
  endtask

  task automatic drain(input string tag);
    int nc, nn;
    ifc.tx_busy = 1'b0;
    for (int i = 0; i < 2000 && (got_c.size() < exp_c.size() || got_n.size() < exp_n.size());
         i++) begin
      tick();
    end
    repeat (6) tick();
    chk({tag, "_len_crlf"}, got_c.size(), exp_c.size());
    chk({tag, "_len_pass"}, got_n.size(), exp_n.size());
    nc = (got_c.size() < exp_c.size()) ? got_c.size() : exp_c.size();
    nn = (got_n.size() < exp_n.size()) ? got_n.size() : exp_n.size();
    for (int i = 0; i < nc; i++) chk({tag, "_byte_crlf"}, got_c[i], exp_c[i]);
    for (int i = 0; i < nn; i++) chk({tag, "_byte_pass"}, got_n[i], exp_n[i]);
    exp_c.delete();
    exp_n.delete();
    got_c.delete();
    got_n.delete();
  endtask

  // Collect accepted bytes and check that a pending request is never altered.
  logic       pc_wr = 1'b0, pc_acc = 1'b1, pc_rst = 1'b1;
  logic       pn_wr = 1'b0, pn_acc = 1'b1;
  logic [7:0] pc_data = 8'h00, pn_data = 8'h00;

  always @(negedge clk) begin
    if (pc_wr && !pc_acc && !pc_rst) begin
      chk("hold_wr_crlf", ifc.tx_wr, 1);
      chk("hold_data_crlf", ifc.tx_data, pc_data);
    end
    if (pn_wr && !pn_acc && !pc_rst) begin
      chk("hold_wr_pass", ifn.tx_wr, 1);
      chk("hold_data_pass", ifn.tx_data, pn_data);
    end
    if (!rst && ifc.tx_wr === 1'b1 && !ifc.tx_busy) got_c.push_back(ifc.tx_data);
    if (!rst && ifn.tx_wr === 1'b1 && !ifc.tx_busy) got_n.push_back(ifn.tx_data);
    pc_wr   = ifc.tx_wr;
    pc_data = ifc.tx_data;
    pc_acc  = !ifc.tx_busy;
    pn_wr   = ifn.tx_wr;
    pn_data = ifn.tx_data;
    pn_acc  = !ifc.tx_busy;
    pc_rst  = rst;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [7:0] b;
    rst              = 1'b1;
    ifc.rx_stb       = 1'b0;
    ifc.rx_data      = 8'h00;
    ifc.tx_busy      = 1'b0;
    ifc.clr_overflow = 1'b0;
    repeat (3) tick();
    chk("rst_wr", ifc.tx_wr, 0);
    chk("rst_data", ifc.tx_data, 8'h00);
    chk("rst_fill", ifc.fill, 0);
    chk("rst_ovf", ifc.overflow, 0);
    rst = 1'b0;
    repeat (6) tick();

    // Single byte latency
    strobe(8'h41, 1'b1);
    chk("t1_fill_n1", ifc.fill, 1);
    chk("t1_wr_n1", ifc.tx_wr, 0);
    tick();
    chk("t1_wr_n2", ifc.tx_wr, 1);
    chk("t1_data_n2", ifc.tx_data, 8'h41);
    tick();
    chk("t1_wr_n3", ifc.tx_wr, 0);
    chk("t1_fill_n3", ifc.fill, 0);
    drain("t1");

    // Fill to capacity, then drop one byte
    ifc.tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) strobe(8'(i), 1'b1);
    chk("t2_fill15", ifc.fill, 15);
    chk("t2_wr", ifc.tx_wr, 1);
    chk("t2_head", ifc.tx_data, 8'h00);
    strobe(8'hff, 1'b1);
    chk("t2_fill16", ifc.fill, 16);
    chk("t2_ovf0", ifc.overflow, 0);
    strobe(8'h77, 1'b0);
    chk("t2_ovf1", ifc.overflow, 1);
    chk("t2_fill_full", ifc.fill, 16);
    chk("t2_ovf_pass", ifn.overflow, 1);
    drain("t2");
    chk("t2_ovf_sticky", ifc.overflow, 1);

    // Overflow coincident with clear
    ifc.clr_overflow = 1'b1;
    tick();
    ifc.clr_overflow = 1'b0;
    chk("t6_pre_clr", ifc.overflow, 0);
    ifc.tx_busy = 1'b1;
    for (int i = 0; i < 17; i++) strobe(8'(8'h20 + i), 1'b1);
    chk("t6_full", ifc.fill, 16);
    ifc.clr_overflow = 1'b1;
    strobe(8'h99, 1'b0);
    ifc.clr_overflow = 1'b0;
    chk("t6_ovf_wins", ifc.overflow, 1);
    ifc.clr_overflow = 1'b1;
    tick();
    ifc.clr_overflow = 1'b0;
    chk("t6_clr_alone", ifc.overflow, 0);
    drain("t6");

    // CR expansion; received LF is never doubled
    strobe(8'h0d, 1'b1);
    strobe(8'h0a, 1'b1);
    strobe(8'h42, 1'b1);
    drain("t3");

    // Long stall holds the request steady, exactly one accept on release
    ifc.tx_busy = 1'b1;
    strobe(8'h55, 1'b1);
    repeat (50) tick();
    chk("t4_wr", ifc.tx_wr, 1);
    chk("t4_data", ifc.tx_data, 8'h55);
    drain("t4");

    // Reset mid-transfer discards everything
    ifc.tx_busy = 1'b1;
    strobe(8'h0d, 1'b1);
    for (int i = 1; i < 5; i++) strobe(8'(i), 1'b1);
    tick();
    chk("t5_wr_pre", ifc.tx_wr, 1);
    chk("t5_fill_pre", ifc.fill, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_wr", ifc.tx_wr, 0);
    chk("t5_fill", ifc.fill, 0);
    chk("t5_ovf", ifc.overflow, 0);
    chk("t5_wr_pass", ifn.tx_wr, 0);
    exp_c.delete();
    exp_n.delete();
    got_c.delete();
    got_n.delete();
    ifc.tx_busy = 1'b0;
    strobe(8'h33, 1'b1);
    chk("t5_lat1", ifc.tx_wr, 0);
    tick();
    chk("t5_lat2_wr", ifc.tx_wr, 1);
    chk("t5_lat2_data", ifc.tx_data, 8'h33);
    drain("t5");

    // Random traffic, throttled so the model never expects a drop
    for (int i = 0; i < 800; i++) begin
      ifc.tx_busy = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 3));
      b = (r == 0) ? 8'h0d : (r == 1) ? 8'h0a : 8'($urandom);
      if ($urandom_range(0, 2) == 0 && (exp_c.size() - got_c.size()) < Depth
          && (exp_n.size() - got_n.size()) < Depth) begin
        strobe(b, 1'b1);
      end else begin
        tick();
      end
    end
    chk("rnd_ovf_crlf", ifc.overflow, 0);
    chk("rnd_ovf_pass", ifn.overflow, 0);
    drain("rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
